plaintext_bit_loader: RTL and testbench
=======================================

// Module: plaintext_bit_loader
// PURPOSE
//  Sequences manual plaintext entry for the small-scale ChaCha20 encrypter.
//  Two entry lines (bit1 = "enter 1", bit2 = "enter 0") are edge-detected into single bit strobes.
//  Bits are shifted MSB-first into a WORD_W-bit plaintext word, which is handed to the XOR/keystream stage
//  over a valid/ready handshake. Tracks bit count and flags entries lost while a word is pending.
// PARAMETERS
//  WORD_W   8   plaintext word width in bits (>=2)
//  CNT_W    4   width of bit_count; must hold WORD_W (>= clog2(WORD_W+1))
// PORTS
//  clk        in   1        system clock, all logic on rising edge
//  rst        in   1        synchronous reset, active-high
//  bit1       in   1        entry line for a '1' bit (level, synchronised upstream)
//  bit2       in   1        entry line for a '0' bit (level, synchronised upstream)
//  clear      in   1        synchronous abort: discard partial/pending word, clear overrun
//  pt_ready   in   1        downstream accepts pt_word this cycle
//  pt_word    out  WORD_W   assembled plaintext word, first-entered bit in MSB
//  pt_valid   out  1        pt_word complete and stable
//  bit_count  out  CNT_W    bits collected in current word (0..WORD_W)
//  overrun    out  1        sticky: an entry was dropped while pt_valid=1
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): pt_word=0, pt_valid=0, bit_count=0, overrun=0, state=COLLECT,
//    flag_q=1 (lines held through reset do not generate a bit).
//  - flag = bit1|bit2; flag_q = flag registered. Entry strobe ent = flag & ~flag_q (rising edge only);
//    a line held high produces exactly one strobe; flag must return low before the next bit.
//  - Entered bit value = bit1 (bit1 wins if both rise together -> '1').
//  - Priority per edge: rst > clear > handshake/entry. clear: pt_word=0, bit_count=0, pt_valid=0,
//    overrun=0, state=COLLECT; flag_q still updates normally.
//  - FSM states: COLLECT, HOLD.
//    COLLECT: on ent, pt_word <= {pt_word[WORD_W-2:0], bit1}, bit_count += 1 (1-cycle latency,
//      visible the cycle after the strobe cycle). If this makes bit_count==WORD_W, go to HOLD and
//      assert pt_valid on the same edge. Without ent, hold all values.
//    HOLD: pt_valid=1, pt_word and bit_count (=WORD_W) frozen. On pt_valid&pt_ready: next edge
//      pt_valid=0, pt_word=0, bit_count=0, state=COLLECT. Any ent while in HOLD (including the
//      handshake cycle) is dropped and sets overrun=1.
//  - pt_ready is ignored in COLLECT; pt_valid never deasserts without handshake, clear or rst.
//  - bit_count never exceeds WORD_W; no wrap-around.
//  - Reset or clear mid-word discards partial bits; no partial word is ever presented.
//  - Pure sequential outputs: all outputs are register outputs, no combinational input->output path.
// TESTING
//  1. rst with bit1=1 held, release rst, keep bit1=1 5 cycles -> bit_count=0, no strobe; drop/raise -> count=1.
//  2. WORD_W=8, enter 1,0,1,1,0,0,1,0 as separate pulses, pt_ready=0 -> pt_valid=1, pt_word=8'hB2, bit_count=8.
//  3. From 2, pulse bit2 twice then pt_ready=1 one cycle -> overrun=1, word 8'hB2 accepted,
//     next cycle pt_valid=0, bit_count=0, pt_word=0.
//  4. bit1 and bit2 rise same cycle -> one bit '1' shifted, bit_count +1 (not +2).
//  5. Enter 3 bits, assert clear with simultaneous bit1 edge -> bit_count=0, pt_word=0, overrun=0.
//  6. Hold pt_ready=1 continuously, enter 16 bits -> two words, each pt_valid for exactly 1 cycle,
//     overrun stays 0; rst asserted mid third word -> all outputs 0 next cycle.

Source files
------------

// File: rtl/plaintext_bit_loader.sv
// Manual plaintext entry: edge-detects two entry lines into bit strobes and shifts them MSB-first
// into a plaintext word. The word is then offered downstream over a valid/ready handshake.
module plaintext_bit_loader #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit1,
    input  logic              bit2,
    input  logic              clear,
    input  logic              pt_ready,
    output logic [WORD_W-1:0] pt_word,
    output logic              pt_valid,
    output logic [CNT_W-1:0]  bit_count,
    output logic              overrun
);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [WORD_W-1:0]   pt_word_reg, pt_word_next;
    logic                pt_valid_reg, pt_valid_next;
    logic [CNT_W-1:0]    bit_count_reg, bit_count_next;
    logic                overrun_reg, overrun_next;
    logic                flag_q_reg;
    logic                flag;
    logic                ent;

    assign flag = bit1 | bit2;
    assign ent  = flag & ~flag_q_reg;

    always_comb begin
        state_next     = state_reg;
        pt_word_next   = pt_word_reg;
        pt_valid_next  = pt_valid_reg;
        bit_count_next = bit_count_reg;
        overrun_next   = overrun_reg;

        if (clear) begin
            state_next     = COLLECT;
            pt_word_next   = '0;
            pt_valid_next  = 1'b0;
            bit_count_next = '0;
            overrun_next   = 1'b0;
        end else begin
            case (state_reg)
                COLLECT: begin
                    if (ent) begin
                        // bit1 wins when both lines rise together
                        pt_word_next   = {pt_word_reg[WORD_W-2:0], bit1};
                        bit_count_next = bit_count_reg + CNT_W'(1);
                        if (bit_count_reg == CNT_W'(WORD_W - 1)) begin
                            state_next    = HOLD;
                            pt_valid_next = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // Entries are never queued behind a pending word; they are lost and flagged.
                    if (ent) begin
                        overrun_next = 1'b1;
                    end
                    if (pt_ready) begin
                        state_next     = COLLECT;
                        pt_word_next   = '0;
                        pt_valid_next  = 1'b0;
                        bit_count_next = '0;
                    end
                end
                default: begin
                    state_next = COLLECT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= COLLECT;
            pt_word_reg   <= '0;
            pt_valid_reg  <= 1'b0;
            bit_count_reg <= '0;
            overrun_reg   <= 1'b0;
            // A line held high through reset must not produce a bit afterwards.
            flag_q_reg    <= 1'b1;
        end else begin
            state_reg     <= state_next;
            pt_word_reg   <= pt_word_next;
            pt_valid_reg  <= pt_valid_next;
            bit_count_reg <= bit_count_next;
            overrun_reg   <= overrun_next;
            flag_q_reg    <= flag;
        end
    end

    assign pt_word   = pt_word_reg;
    assign pt_valid  = pt_valid_reg;
    assign bit_count = bit_count_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_plaintext_bit_loader.sv
// Directed testbench for plaintext_bit_loader (WORD_W=8, CNT_W=4).
module tb_plaintext_bit_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit1;
    logic       bit2;
    logic       clear;
    logic       pt_ready;
    logic [7:0] pt_word;
    logic       pt_valid;
    logic [3:0] bit_count;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    // handshake monitor used by the back-to-back scenario
    logic       mon_en = 1'b0;
    int         valid_cycles = 0;
    int         ncap = 0;
    logic [7:0] cap_words [0:3];

    plaintext_bit_loader #(.WORD_W(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bit1      (bit1),
        .bit2      (bit2),
        .clear     (clear),
        .pt_ready  (pt_ready),
        .pt_word   (pt_word),
        .pt_valid  (pt_valid),
        .bit_count (bit_count),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en && pt_valid) begin
            valid_cycles++;
            if (pt_ready && ncap < 4) begin
                cap_words[ncap] = pt_word;
                ncap++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one entry pulse: line high for one cycle, then low for one cycle
    task automatic pulse(input logic b1, input logic b2);
        bit1 = b1;
        bit2 = b2;
        tick();
        bit1 = 1'b0;
        bit2 = 1'b0;
        tick();
    endtask

    task automatic enter_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) pulse(1'b1, 1'b0);
            else      pulse(1'b0, 1'b1);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic check_outputs(input string name, input logic [7:0] e_word, input logic e_valid,
                                 input logic [3:0] e_count, input logic e_ovr);
        total++;
        if (pt_word !== e_word) begin
            bad++;
            $display("FAIL %s pt_word got=%h exp=%h", name, pt_word, e_word);
        end
        total++;
        if (pt_valid !== e_valid) begin
            bad++;
            $display("FAIL %s pt_valid got=%b exp=%b", name, pt_valid, e_valid);
        end
        total++;
        if (bit_count !== e_count) begin
            bad++;
            $display("FAIL %s bit_count got=%0d exp=%0d", name, bit_count, e_count);
        end
        total++;
        if (overrun !== e_ovr) begin
            bad++;
            $display("FAIL %s overrun got=%b exp=%b", name, overrun, e_ovr);
        end
        $display("check %s: word=%h valid=%b count=%0d overrun=%b", name, pt_word, pt_valid, bit_count, overrun);
    endtask

    task automatic test_reset();
        rst = 1'b1; bit1 = 1'b1; bit2 = 1'b0; clear = 1'b0; pt_ready = 1'b0;
        tick();
        tick();
        check_outputs("reset_state", 8'h00, 1'b0, 4'd0, 1'b0);
        rst = 1'b0;
        repeat (5) tick();
        check_outputs("held_line_no_strobe", 8'h00, 1'b0, 4'd0, 1'b0);
        bit1 = 1'b0;
        tick();
        bit1 = 1'b1;
        tick();
        check_outputs("reraise_one_bit", 8'h01, 1'b0, 4'd1, 1'b0);
        bit1 = 1'b0;
        tick();
        do_clear();
        check_outputs("reset_cleanup", 8'h00, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic test_collect();
        logic [7:0] pat;
        pat = 8'hB2;
        pt_ready = 1'b0;
        for (int i = 7; i >= 1; i--) begin
            if (pat[i]) pulse(1'b1, 1'b0);
            else        pulse(1'b0, 1'b1);
        end
        check_outputs("seven_bits_partial", 8'h59, 1'b0, 4'd7, 1'b0);
        pulse(1'b0, 1'b1);
        check_outputs("word_complete", 8'hB2, 1'b1, 4'd8, 1'b0);
        repeat (3) tick();
        check_outputs("word_held_no_ready", 8'hB2, 1'b1, 4'd8, 1'b0);
    endtask

    task automatic test_overrun_handshake();
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        check_outputs("overrun_set", 8'hB2, 1'b1, 4'd8, 1'b1);
        pt_ready = 1'b1;
        #3;
        check_outputs("accept_cycle", 8'hB2, 1'b1, 4'd8, 1'b1);
        tick();
        pt_ready = 1'b0;
        check_outputs("after_accept", 8'h00, 1'b0, 4'd0, 1'b1);
        tick();
        check_outputs("overrun_sticky", 8'h00, 1'b0, 4'd0, 1'b1);
        do_clear();
        check_outputs("clear_overrun", 8'h00, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic test_simultaneous();
        pulse(1'b1, 1'b1);
        check_outputs("both_rise_one_bit", 8'h01, 1'b0, 4'd1, 1'b0);
        pulse(1'b0, 1'b1);
        check_outputs("then_zero", 8'h02, 1'b0, 4'd2, 1'b0);
        do_clear();
    endtask

    task automatic test_clear();
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        check_outputs("three_bits", 8'h05, 1'b0, 4'd3, 1'b0);
        clear = 1'b1;
        bit1  = 1'b1;
        tick();
        clear = 1'b0;
        check_outputs("clear_beats_entry", 8'h00, 1'b0, 4'd0, 1'b0);
        tick();
        bit1 = 1'b0;
        tick();
        check_outputs("no_late_strobe", 8'h00, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic test_back_to_back();
        pt_ready = 1'b1;
        valid_cycles = 0;
        ncap = 0;
        mon_en = 1'b1;
        enter_byte(8'hA5);
        enter_byte(8'h3C);
        tick();
        mon_en = 1'b0;
        total++;
        if (valid_cycles !== 2) begin
            bad++;
            $display("FAIL b2b_valid_cycles got=%0d exp=2", valid_cycles);
        end
        total++;
        if (ncap !== 2) begin
            bad++;
            $display("FAIL b2b_word_count got=%0d exp=2", ncap);
        end else begin
            total++;
            if (cap_words[0] !== 8'hA5) begin
                bad++;
                $display("FAIL b2b_word0 got=%h exp=a5", cap_words[0]);
            end
            total++;
            if (cap_words[1] !== 8'h3C) begin
                bad++;
                $display("FAIL b2b_word1 got=%h exp=3c", cap_words[1]);
            end
        end
        $display("check b2b: valid_cycles=%0d words=%0d", valid_cycles, ncap);
        check_outputs("b2b_idle", 8'h00, 1'b0, 4'd0, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        check_outputs("third_word_partial", 8'h06, 1'b0, 4'd3, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_outputs("rst_mid_word", 8'h00, 1'b0, 4'd0, 1'b0);
        pt_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_collect();
        test_overrun_handshake();
        test_simultaneous();
        test_clear();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
